// File: rtl/evt_count_snap_pkg.sv
// Shared types and constants for the event counter
// with snapshot handshake.
package evt_count_snap_pkg;

  localparam int WIDTH_DEF = 8;

  localparam logic [WIDTH_DEF-1:0] ALL_ONES_DEF =
    {WIDTH_DEF{1'b1}};

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } snap_state_e;

endpackage

// File: rtl/evt_count_snap_inc_comb.sv
// Combinational +1 stage; interchangeable with the
// gate-level incrementer netlist.
module inc_comb
  import evt_count_snap_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] next,
  output logic             co
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum  = {1'b0, a} + {{WIDTH{1'b0}}, 1'b1};
    next = sum[WIDTH-1:0];
    co   = sum[WIDTH];
  end

endmodule

// File: rtl/evt_count_snap.sv
// Event counter with wrap/saturate policy, sticky
// overflow and a valid/ready snapshot port.
module evt_count_snap
  import evt_count_snap_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             evt,
  input  logic             clr,
  input  logic             snap_req,
  input  logic             snap_clr,
  output logic             snap_valid,
  input  logic             snap_ready,
  output logic [WIDTH-1:0] snap_data,
  output logic             snap_ovf,
  output logic [WIDTH-1:0] count,
  output logic             ovf
);

  localparam bit SAT = (SATURATE != 0);

  snap_state_e      state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] sdata_q, sdata_d;
  logic             sovf_q, sovf_d;

  logic [WIDTH-1:0] nxt;
  logic             co;
  logic             inc;
  logic             cap;
  logic             clr_any;

  inc_comb #(.WIDTH(WIDTH)) u_inc (
    .a    (count_q),
    .next (nxt),
    .co   (co)
  );

  always_comb begin
    inc     = en & evt;
    cap     = (state_q == IDLE) & snap_req;
    clr_any = clr | (cap & snap_clr);
  end

  // A clear never swallows a simultaneous event.
  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clr_any) begin
      count_d = inc ? {{(WIDTH-1){1'b0}}, 1'b1}
                    : '0;
      ovf_d   = 1'b0;
    end else if (inc) begin
      count_d = (co && SAT) ? count_q : nxt;
      ovf_d   = ovf_q | co;
    end
  end

  always_comb begin
    state_d = state_q;
    sdata_d = sdata_q;
    sovf_d  = sovf_q;
    unique case (state_q)
      IDLE: begin
        if (snap_req) begin
          sdata_d = count_q;
          sovf_d  = ovf_q;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (snap_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      ovf_q   <= 1'b0;
      sdata_q <= '0;
      sovf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      sdata_q <= sdata_d;
      sovf_q  <= sovf_d;
    end
  end

  assign snap_valid = (state_q == HOLD);
  assign snap_data  = sdata_q;
  assign snap_ovf   = sovf_q;
  assign count      = count_q;
  assign ovf        = ovf_q;

endmodule
